// File: rtl/trashbin_bus_pkg.sv
// Shared types and constants for the memory-mapped peripheral bus initiators.
package trashbin_bus_pkg;

  localparam int PERIPH_ADDR_W = 14;
  localparam int BUS_DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bus_state_e;

  // Internal record of why a transaction completed with an error.
  typedef logic [1:0] err_cause_t;
  localparam err_cause_t ERR_NONE     = 2'd0;
  localparam err_cause_t ERR_MISALIGN = 2'd1;
  localparam err_cause_t ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mm_timeout_counter.sv
// Saturating wait-cycle counter: load starts at 1, counts while enabled,
// flags expiry once LIMIT wait cycles have elapsed.
module mm_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (en && (count != MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  // The counter holds k during wait cycle k, so expiry marks the last allowed cycle.
  assign expired = (count == MAX);

endmodule

// File: rtl/mm_peripheral_initiator.sv
// Initiator end of the memory-mapped peripheral bus: one CPU request at a
// time becomes a single strobe, a bounded wait for PeriphReady and a response pulse.
module mm_peripheral_initiator
  import trashbin_bus_pkg::*;
#(
  parameter int ADDR_W         = PERIPH_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CoreClock,
  input  logic              CoreReset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [31:0]       ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspRData,
  output logic              RspError,
  output logic [ADDR_W-1:0] AddressBus_P,
  output logic [DATA_W-1:0] DataWriteBus_P,
  output logic              WriteAssert_P,
  output logic              ReadAssert_P,
  input  logic [DATA_W-1:0] DataReadBus_P,
  input  logic              PeriphReady
);

  bus_state_e  state, state_d;
  err_cause_t  cause;
  logic        write_q, write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic        write_strobe_d, read_strobe_d;
  logic        expired;

  // Upper address bits are decoded upstream.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ReqAddr[31:ADDR_W+2];

  mm_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CoreClock),
    .rst_n   (CoreReset_n),
    .load    (state == ISSUE),
    .en      (state == WAIT),
    .expired (expired)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state;
    cause          = ERR_NONE;
    write_d        = write_q;
    addr_d         = AddressBus_P;
    wdata_d        = DataWriteBus_P;
    rdata_d        = '0;
    write_strobe_d = 1'b0;
    read_strobe_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (ReqValid && ReqReady) begin
          write_d = ReqWrite;
          if (ReqAddr[1:0] != 2'b00) begin
            state_d = RESP;
            cause   = ERR_MISALIGN;
          end else begin
            state_d        = ISSUE;
            addr_d         = ReqAddr[ADDR_W+1:2];
            wdata_d        = ReqWrite ? ReqWData : '0;
            write_strobe_d = ReqWrite;
            read_strobe_d  = !ReqWrite;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Ready takes priority over expiry, so a ready on the final cycle succeeds.
        if (PeriphReady) begin
          state_d = RESP;
          if (!write_q) rdata_d = DataReadBus_P;
        end else if (expired) begin
          state_d = RESP;
          cause   = ERR_TIMEOUT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      ReqReady       <= 1'b0;
      RspValid       <= 1'b0;
      RspRData       <= '0;
      RspError       <= 1'b0;
      AddressBus_P   <= '0;
      DataWriteBus_P <= '0;
      WriteAssert_P  <= 1'b0;
      ReadAssert_P   <= 1'b0;
    end else begin
      state          <= state_d;
      write_q        <= write_d;
      ReqReady       <= (state_d == IDLE);
      RspValid       <= (state_d == RESP);
      RspRData       <= rdata_d;
      RspError       <= (cause != ERR_NONE);
      AddressBus_P   <= addr_d;
      DataWriteBus_P <= wdata_d;
      WriteAssert_P  <= write_strobe_d;
      ReadAssert_P   <= read_strobe_d;
    end
  end

endmodule

// File: tb/tb_mm_peripheral_initiator.sv
// Directed bench for mm_peripheral_initiator: writes, reads, misalignment,
// timeout, delayed ready and reset during a transaction.
module tb_mm_peripheral_initiator;

  logic        CoreClock;
  logic        CoreReset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspRData;
  logic        RspError;
  logic [13:0] AddressBus_P;
  logic [31:0] DataWriteBus_P;
  logic        WriteAssert_P;
  logic        ReadAssert_P;
  logic [31:0] DataReadBus_P;
  logic        PeriphReady;

  int tests_run = 0;
  int tests_failed = 0;

  mm_peripheral_initiator #(
    .ADDR_W         (14),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .CoreClock      (CoreClock),
    .CoreReset_n    (CoreReset_n),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .ReqWrite       (ReqWrite),
    .ReqAddr        (ReqAddr),
    .ReqWData       (ReqWData),
    .RspValid       (RspValid),
    .RspRData       (RspRData),
    .RspError       (RspError),
    .AddressBus_P   (AddressBus_P),
    .DataWriteBus_P (DataWriteBus_P),
    .WriteAssert_P  (WriteAssert_P),
    .ReadAssert_P   (ReadAssert_P),
    .DataReadBus_P  (DataReadBus_P),
    .PeriphReady    (PeriphReady)
  );

  initial begin
    CoreClock = 1'b0;
    forever #5 CoreClock = ~CoreClock;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CoreClock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ReqReady"},       32'(ReqReady),      32'd0);
    check({tag, " RspValid"},       32'(RspValid),      32'd0);
    check({tag, " RspRData"},       RspRData,           32'd0);
    check({tag, " RspError"},       32'(RspError),      32'd0);
    check({tag, " AddressBus_P"},   32'(AddressBus_P),  32'd0);
    check({tag, " DataWriteBus_P"}, DataWriteBus_P,     32'd0);
    check({tag, " WriteAssert_P"},  32'(WriteAssert_P), 32'd0);
    check({tag, " ReadAssert_P"},   32'(ReadAssert_P),  32'd0);
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqWData = wdata;
  endtask

  initial begin
    CoreReset_n   = 1'b1;
    ReqValid      = 1'b0;
    ReqWrite      = 1'b0;
    ReqAddr       = '0;
    ReqWData      = '0;
    DataReadBus_P = '0;
    PeriphReady   = 1'b0;

    // Reset state
    #2 CoreReset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) tick();
    check("reset held ReqReady", 32'(ReqReady), 32'd0);
    @(negedge CoreClock);
    CoreReset_n = 1'b1;
    tick();
    check("post-reset ReqReady", 32'(ReqReady), 32'd1);

    // 1: zero-wait write; payload change after acceptance must not leak through
    PeriphReady = 1'b1;
    request(1'b1, 32'h0000_0010, 32'hA5A5_0001);
    tick();
    ReqValid = 1'b0;
    ReqWData = 32'hFFFF_FFFF;
    check("wr T+1 WriteAssert_P", 32'(WriteAssert_P), 32'd1);
    check("wr T+1 ReadAssert_P",  32'(ReadAssert_P),  32'd0);
    check("wr T+1 AddressBus_P",  32'(AddressBus_P),  32'h004);
    check("wr T+1 DataWriteBus_P", DataWriteBus_P,    32'hA5A5_0001);
    check("wr T+1 ReqReady",      32'(ReqReady),      32'd0);
    tick();
    check("wr T+2 WriteAssert_P", 32'(WriteAssert_P), 32'd0);
    check("wr T+2 RspValid",      32'(RspValid),      32'd0);
    check("wr T+2 DataWriteBus_P", DataWriteBus_P,    32'hA5A5_0001);
    tick();
    check("wr T+3 RspValid",      32'(RspValid),      32'd1);
    check("wr T+3 RspError",      32'(RspError),      32'd0);
    check("wr T+3 RspRData",      RspRData,           32'd0);
    tick();
    check("wr T+4 RspValid",      32'(RspValid),      32'd0);
    check("wr T+4 ReqReady",      32'(ReqReady),      32'd1);

    // 2: zero-wait read
    DataReadBus_P = 32'hDEAD_BEEF;
    request(1'b0, 32'h0000_0008, 32'h1111_2222);
    tick();
    ReqValid = 1'b0;
    check("rd T+1 ReadAssert_P",  32'(ReadAssert_P),  32'd1);
    check("rd T+1 WriteAssert_P", 32'(WriteAssert_P), 32'd0);
    check("rd T+1 AddressBus_P",  32'(AddressBus_P),  32'h002);
    check("rd T+1 DataWriteBus_P", DataWriteBus_P,    32'd0);
    tick();
    check("rd T+2 ReadAssert_P",  32'(ReadAssert_P),  32'd0);
    tick();
    check("rd T+3 RspValid",      32'(RspValid),      32'd1);
    check("rd T+3 RspRData",      RspRData,           32'hDEAD_BEEF);
    check("rd T+3 RspError",      32'(RspError),      32'd0);
    tick();
    check("rd T+4 RspRData idle", RspRData,           32'd0);
    check("rd T+4 ReqReady",      32'(ReqReady),      32'd1);

    // 3: misaligned read, no strobe, error at T+1
    request(1'b0, 32'h0000_0006, 32'd0);
    tick();
    ReqValid = 1'b0;
    check("mis T+1 RspValid",     32'(RspValid),      32'd1);
    check("mis T+1 RspError",     32'(RspError),      32'd1);
    check("mis T+1 RspRData",     RspRData,           32'd0);
    check("mis T+1 ReadAssert_P", 32'(ReadAssert_P),  32'd0);
    check("mis T+1 WriteAssert_P", 32'(WriteAssert_P), 32'd0);
    check("mis T+1 AddressBus_P held", 32'(AddressBus_P), 32'h002);
    check("mis T+1 ReqReady",     32'(ReqReady),      32'd0);
    tick();
    check("mis T+2 ReqReady",     32'(ReqReady),      32'd1);
    check("mis T+2 RspValid",     32'(RspValid),      32'd0);
    check("mis T+2 ReadAssert_P", 32'(ReadAssert_P),  32'd0);

    // 4: timeout with TIMEOUT_CYCLES=4, then a normal write
    PeriphReady   = 1'b0;
    DataReadBus_P = 32'hBAD0_BAD0;
    request(1'b0, 32'h0000_000C, 32'd0);
    tick();
    ReqValid = 1'b0;
    check("to T+1 ReadAssert_P",  32'(ReadAssert_P),  32'd1);
    check("to T+1 AddressBus_P",  32'(AddressBus_P),  32'h003);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("to wait k=%0d RspValid", k), 32'(RspValid), 32'd0);
    end
    tick();
    check("to T+6 RspValid",      32'(RspValid),      32'd1);
    check("to T+6 RspError",      32'(RspError),      32'd1);
    check("to T+6 RspRData",      RspRData,           32'd0);
    tick();
    check("to T+7 ReqReady",      32'(ReqReady),      32'd1);
    check("to T+7 RspError idle", 32'(RspError),      32'd0);
    PeriphReady = 1'b1;
    request(1'b1, 32'h0000_0020, 32'h5555_AAAA);
    tick();
    ReqValid = 1'b0;
    check("after-to WriteAssert_P", 32'(WriteAssert_P), 32'd1);
    check("after-to AddressBus_P",  32'(AddressBus_P),  32'h008);
    repeat (2) tick();
    check("after-to RspValid",    32'(RspValid),      32'd1);
    check("after-to RspError",    32'(RspError),      32'd0);
    tick();

    // 5: ready arrives at wait cycle k=3
    PeriphReady   = 1'b0;
    DataReadBus_P = 32'd0;
    request(1'b0, 32'h0000_0014, 32'd0);
    tick();
    ReqValid = 1'b0;
    check("k3 T+1 ReadAssert_P",  32'(ReadAssert_P),  32'd1);
    repeat (3) tick();
    check("k3 T+4 RspValid",      32'(RspValid),      32'd0);
    PeriphReady   = 1'b1;
    DataReadBus_P = 32'h1234_5678;
    tick();
    PeriphReady   = 1'b0;
    DataReadBus_P = 32'd0;
    check("k3 T+5 RspValid",      32'(RspValid),      32'd1);
    check("k3 T+5 RspRData",      RspRData,           32'h1234_5678);
    check("k3 T+5 RspError",      32'(RspError),      32'd0);
    tick();

    // 6: reset during WAIT discards the transaction
    request(1'b0, 32'h0000_0018, 32'd0);
    tick();
    ReqValid = 1'b0;
    check("rst T+1 ReadAssert_P", 32'(ReadAssert_P),  32'd1);
    tick();
    CoreReset_n = 1'b0;
    #1 check_all_zero("mid-reset");
    @(negedge CoreClock);
    CoreReset_n = 1'b1;
    #1 check("release ReqReady",  32'(ReqReady),      32'd0);
    tick();
    check("release+1 ReqReady",   32'(ReqReady),      32'd1);
    check("release+1 RspValid",   32'(RspValid),      32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("release+%0d RspValid", i + 2), 32'(RspValid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
